// File: rtl/tiny_dnn_axis_pkg.sv
// tiny_dnn_axis_pkg: shared widths, FSM states and the buffered beat record
package tiny_dnn_axis_pkg;
    localparam int DW = 32;
    localparam int LW = 12;
    localparam int FW = 8;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
endpackage

// File: rtl/tiny_dnn_axis_if.sv
// tiny_dnn_axis_if: AXI4-Stream bundle with master/slave views
interface tiny_dnn_axis_if #(parameter int DW = tiny_dnn_axis_pkg::DW);
    logic            TVALID;
    logic            TREADY;
    logic            TLAST;
    logic [DW-1:0]   TDATA;
    logic [DW/8-1:0] TKEEP;
    modport master (output TVALID, TDATA, TKEEP, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TKEEP, TLAST, output TREADY);
endinterface

// File: rtl/tiny_dnn_axis_skid.sv
// tiny_dnn_axis_skid: 2-entry FIFO with registered head output and flush
module tiny_dnn_axis_skid
    import tiny_dnn_axis_pkg::*;
#(
    parameter type T = beat_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  T           din,
    output T           dout,
    output logic [1:0] cnt
);
    T e0_q, e0_d, e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;
    logic do_pop, do_push, wr_lo;

    // pop shifts the tail forward; a push lands in the first free slot after that shift
    always_comb begin
        do_pop  = pop && (cnt_q != 2'd0);
        do_push = push && (cnt_q != 2'd2 || do_pop);
        wr_lo   = do_push && (cnt_q == {1'b0, do_pop});
        e0_d    = wr_lo ? din : do_pop ? e1_q : e0_q;
        e1_d    = (do_push && !wr_lo) ? din : e1_q;
        cnt_d   = flush ? 2'd0 : cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // storage and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = e0_q;
    assign cnt  = cnt_q;
endmodule

// File: rtl/tiny_dnn_axis_framer.sv
// tiny_dnn_axis_framer: re-frames an untagged result stream with TLAST every len beats
module tiny_dnn_axis_framer #(
    parameter int DW = tiny_dnn_axis_pkg::DW,
    parameter int LW = tiny_dnn_axis_pkg::LW,
    parameter int FW = tiny_dnn_axis_pkg::FW
) (
    input  logic          AXIS_ACLK,
    input  logic          AXIS_ARESETN,
    input  logic          start,
    input  logic          abort,
    input  logic [LW-1:0] len,
    input  logic [FW-1:0] nfrm,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [LW-1:0] beat_cnt,
    output logic [FW-1:0] frm_cnt,
    tiny_dnn_axis_if.slave  S_AXIS,
    tiny_dnn_axis_if.master M_AXIS
);
    import tiny_dnn_axis_pkg::*;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } rec_t;

    state_t state_q, state_d;
    logic [LW-1:0] len_q, len_d, beat_q, beat_d;
    logic [FW-1:0] nfrm_q, nfrm_d, frm_q, frm_d;
    logic err_q, err_d, done_q, done_d;
    logic [1:0] cnt;
    logic acc, last, pop;
    rec_t din, head;

    assign S_AXIS.TREADY = (state_q == RUN) && (cnt != 2'd2);
    assign acc           = S_AXIS.TVALID && S_AXIS.TREADY;
    assign last          = beat_q == len_q - LW'(1);
    assign pop           = M_AXIS.TVALID && M_AXIS.TREADY;
    assign din           = '{data: S_AXIS.TDATA, last: last};

    tiny_dnn_axis_skid #(.T(rec_t)) u_skid (
        .clk   (AXIS_ACLK),
        .rst_n (AXIS_ARESETN),
        .flush (abort),
        .push  (acc),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .cnt   (cnt)
    );

    assign M_AXIS.TVALID = cnt != 2'd0;
    assign M_AXIS.TDATA  = head.data;
    assign M_AXIS.TLAST  = head.last && M_AXIS.TVALID;
    assign M_AXIS.TKEEP  = {(DW/8){M_AXIS.TVALID}};

    // run control: abort overrides everything, then start/accept/drain per state
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        nfrm_d  = nfrm_q;
        beat_d  = beat_q;
        frm_d   = frm_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            beat_d  = '0;
            frm_d   = '0;
        end else if (state_q == IDLE && start) begin
            if (len != '0 && nfrm != '0) begin
                state_d = RUN;
                len_d   = len;
                nfrm_d  = nfrm;
                beat_d  = '0;
                frm_d   = '0;
                err_d   = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (state_q == RUN && acc) begin
            beat_d  = last ? '0 : beat_q + LW'(1);
            frm_d   = last ? frm_q + FW'(1) : frm_q;
            state_d = (last && frm_q == nfrm_q - FW'(1)) ? FLUSH : RUN;
        end else if (state_q == FLUSH && cnt == 2'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
    end

    // control and counter registers
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q <= IDLE;
            len_q   <= '0;
            nfrm_q  <= '0;
            beat_q  <= '0;
            frm_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            nfrm_q  <= nfrm_d;
            beat_q  <= beat_d;
            frm_q   <= frm_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign err      = err_q;
    assign beat_cnt = beat_q;
    assign frm_cnt  = frm_q;
endmodule

// File: tb/tb_tiny_dnn_axis_framer.sv
// tb_tiny_dnn_axis_framer: directed vector table plus hand-written corner sequences
module tb_tiny_dnn_axis_framer;
    logic        clk = 1'b0;
    logic        AXIS_ARESETN = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] len = '0;
    logic [7:0]  nfrm = '0;
    logic        busy, done, err;
    logic [11:0] beat_cnt;
    logic [7:0]  frm_cnt;
    int          checks = 0;
    int          errors = 0;
    int          busy_cyc;

    tiny_dnn_axis_if #(.DW(32)) S_AXIS ();
    tiny_dnn_axis_if #(.DW(32)) M_AXIS ();

    tiny_dnn_axis_framer dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESETN (AXIS_ARESETN),
        .start        (start),
        .abort        (abort),
        .len          (len),
        .nfrm         (nfrm),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .beat_cnt     (beat_cnt),
        .frm_cnt      (frm_cnt),
        .S_AXIS       (S_AXIS),
        .M_AXIS       (M_AXIS)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [11:0] len;
        logic [7:0]  nfrm;
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic        e_sr;
        logic        e_mv;
        logic [31:0] e_md;
        logic        e_ml;
        logic        e_busy;
        logic        e_done;
        logic [11:0] e_beat;
        logic [7:0]  e_frm;
    } vec_t;

    vec_t tab[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " beat_cnt"}, beat_cnt, 0);
        chk({tag, " frm_cnt"}, frm_cnt, 0);
        chk({tag, " s_tready"}, S_AXIS.TREADY, 0);
        chk({tag, " m_tvalid"}, M_AXIS.TVALID, 0);
        chk({tag, " m_tlast"}, M_AXIS.TLAST, 0);
        chk({tag, " m_tdata"}, M_AXIS.TDATA, 0);
        chk({tag, " m_tkeep"}, M_AXIS.TKEEP, 0);
    endtask

    task automatic do_start(input int l, input int n, input int base);
        @(negedge clk);
        start         = 1'b1;
        abort         = 1'b0;
        len           = 12'(l);
        nfrm          = 8'(n);
        S_AXIS.TVALID = 1'b1;
        S_AXIS.TDATA  = 32'(base);
        M_AXIS.TREADY = 1'b1;
    endtask

    // drives an always-valid source and a sink stalled for the first hold cycles, checking every delivered beat
    task automatic collect(input int l, input int n, input int base, input int hold, input string tag);
        int got = 0;
        int cyc = 0;
        bit fin = 0;
        bit acc = 0;
        bit stall = 0;
        bit pbusy = 1;
        logic [31:0] pd = '0;
        busy_cyc = 0;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (acc) S_AXIS.TDATA = S_AXIS.TDATA + 1;
            if (busy) busy_cyc++;
            if (stall) begin
                chk({tag, " stalled tvalid"}, M_AXIS.TVALID, 1);
                chk({tag, " stalled tdata"}, M_AXIS.TDATA, pd);
            end
            chk({tag, " tkeep"}, M_AXIS.TKEEP, {4{M_AXIS.TVALID}});
            if (hold >= 3 && cyc == hold) begin
                chk({tag, " full s_tready"}, S_AXIS.TREADY, 0);
                chk({tag, " full m_tvalid"}, M_AXIS.TVALID, 1);
                chk({tag, " full head"}, M_AXIS.TDATA, 32'(base));
                chk({tag, " full beat_cnt"}, beat_cnt, 32'(2 % l));
            end
            if (done) begin
                chk({tag, " busy at done"}, busy, 0);
                chk({tag, " busy before done"}, pbusy, 1);
                fin = 1;
            end
            pbusy         = busy;
            M_AXIS.TREADY = cyc > hold;
            acc           = S_AXIS.TVALID && S_AXIS.TREADY;
            stall         = M_AXIS.TVALID && !M_AXIS.TREADY;
            pd            = M_AXIS.TDATA;
            if (M_AXIS.TVALID && M_AXIS.TREADY) begin
                chk($sformatf("%s beat%0d data", tag, got), M_AXIS.TDATA, 32'(base + got));
                chk($sformatf("%s beat%0d last", tag, got), M_AXIS.TLAST, 32'((got + 1) % l == 0));
                got++;
            end
        end
        S_AXIS.TVALID = 1'b0;
        chk({tag, " beat count"}, got, l * n);
        chk({tag, " done seen"}, fin, 1);
        chk({tag, " frm_cnt"}, frm_cnt, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tab = '{
            '{1, 4, 2, 1, 32'h100, 1,  0, 0, 32'h000, 0, 0, 0, 0, 0},
            '{0, 4, 2, 1, 32'h100, 1,  1, 0, 32'h000, 0, 1, 0, 0, 0},
            '{0, 4, 2, 1, 32'h101, 1,  1, 1, 32'h100, 0, 1, 0, 1, 0},
            '{0, 4, 2, 1, 32'h102, 1,  1, 1, 32'h101, 0, 1, 0, 2, 0},
            '{0, 4, 2, 1, 32'h103, 1,  1, 1, 32'h102, 0, 1, 0, 3, 0},
            '{0, 4, 2, 1, 32'h104, 1,  1, 1, 32'h103, 1, 1, 0, 0, 1},
            '{0, 4, 2, 1, 32'h105, 1,  1, 1, 32'h104, 0, 1, 0, 1, 1},
            '{0, 4, 2, 1, 32'h106, 1,  1, 1, 32'h105, 0, 1, 0, 2, 1},
            '{0, 4, 2, 1, 32'h107, 1,  1, 1, 32'h106, 0, 1, 0, 3, 1},
            '{0, 4, 2, 1, 32'h108, 1,  0, 1, 32'h107, 1, 1, 0, 0, 2},
            '{0, 4, 2, 0, 32'h000, 1,  0, 0, 32'h000, 0, 1, 0, 0, 2},
            '{0, 4, 2, 0, 32'h000, 1,  0, 0, 32'h000, 0, 0, 1, 0, 2},
            '{0, 4, 2, 0, 32'h000, 1,  0, 0, 32'h000, 0, 0, 0, 0, 2}
        };
        S_AXIS.TVALID = 1'b0;
        S_AXIS.TDATA  = '0;
        S_AXIS.TKEEP  = '1;
        S_AXIS.TLAST  = 1'b0;
        M_AXIS.TREADY = 1'b0;

        repeat (2) @(negedge clk);
        chk_zero("reset");
        AXIS_ARESETN = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk($sformatf("row%0d s_tready", i), S_AXIS.TREADY, tab[i].e_sr);
            chk($sformatf("row%0d m_tvalid", i), M_AXIS.TVALID, tab[i].e_mv);
            chk($sformatf("row%0d m_tkeep", i), M_AXIS.TKEEP, {4{tab[i].e_mv}});
            chk($sformatf("row%0d busy", i), busy, tab[i].e_busy);
            chk($sformatf("row%0d done", i), done, tab[i].e_done);
            chk($sformatf("row%0d beat_cnt", i), beat_cnt, tab[i].e_beat);
            chk($sformatf("row%0d frm_cnt", i), frm_cnt, tab[i].e_frm);
            if (tab[i].e_mv) begin
                chk($sformatf("row%0d m_tdata", i), M_AXIS.TDATA, tab[i].e_md);
                chk($sformatf("row%0d m_tlast", i), M_AXIS.TLAST, tab[i].e_ml);
            end
            start         = tab[i].start;
            len           = tab[i].len;
            nfrm          = tab[i].nfrm;
            S_AXIS.TVALID = tab[i].sv;
            S_AXIS.TDATA  = tab[i].sd;
            M_AXIS.TREADY = tab[i].mr;
        end

        do_start(1, 3, 32'h200);
        collect(1, 3, 32'h200, 0, "len1");
        chk("len1 busy cycles >= 3", busy_cyc >= 3, 1);

        do_start(3, 1, 32'h300);
        collect(3, 1, 32'h300, 5, "backpressure");

        @(negedge clk);
        start = 1'b1; len = 12'd0; nfrm = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("len0 err", err, 1);
        chk("len0 busy", busy, 0);
        start = 1'b1; len = 12'd2; nfrm = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("nfrm0 err", err, 1);
        chk("nfrm0 busy", busy, 0);
        do_start(2, 1, 32'h400);
        collect(2, 1, 32'h400, 0, "after err");
        chk("err cleared", err, 0);

        do_start(4, 1, 32'h500);
        @(negedge clk);
        start = 1'b0;
        chk("abort pre s_tready", S_AXIS.TREADY, 1);
        @(negedge clk);
        S_AXIS.TDATA = 32'h501;
        chk("abort pre head0", M_AXIS.TDATA, 32'h500);
        @(negedge clk);
        chk("abort pre beat_cnt", beat_cnt, 2);
        chk("abort pre pending", M_AXIS.TVALID, 1);
        chk("abort pre head1", M_AXIS.TDATA, 32'h501);
        S_AXIS.TVALID = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort m_tvalid", M_AXIS.TVALID, 0);
        chk("abort s_tready", S_AXIS.TREADY, 0);
        chk("abort busy", busy, 0);
        chk("abort beat_cnt", beat_cnt, 0);
        chk("abort frm_cnt", frm_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("abort no done %0d", i), done, 0);
            @(negedge clk);
        end
        start = 1'b1; abort = 1'b1; len = 12'd2; nfrm = 8'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort beats start busy", busy, 0);

        do_start(4, 1, 32'h600);
        @(negedge clk);
        start = 1'b0;
        M_AXIS.TREADY = 1'b0;
        @(negedge clk);
        chk("pre-reset m_tvalid", M_AXIS.TVALID, 1);
        #2 AXIS_ARESETN = 1'b0;
        #1 chk_zero("async reset");
        @(negedge clk);
        AXIS_ARESETN = 1'b1;
        do_start(2, 2, 32'h700);
        collect(2, 2, 32'h700, 0, "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tiny_dnn_axis_framer.md
Name: tiny_dnn_axis_framer

Overview:
- Receive-side partner of the accelerator's result stream. The accelerator's stream master emits dst_data with TLAST tied low, so a DMA S2MM channel cannot close a transfer on its own.
- This block sits between the accelerator's M_AXIS and the DMA. It accepts result beats and re-emits them through a 2-entry buffer.
- It asserts TLAST on the last beat of each programmed frame and signals done once all frames have drained.

Parameters:
- DW, 32, stream data width.
- LW, 12, width of frame-length field; matches the 12-bit ds/dst address range.
- FW, 8, width of frame-count field.

Ports:
- AXIS_ACLK  in  1  clock.
- AXIS_ARESETN  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches len/nfrm when in IDLE.
- abort  in  1  synchronous clear to IDLE; drops buffered beats.
- len  in  LW  beats per frame, 1..4095.
- nfrm  in  FW  frames per run, 1..255.
- busy  out  1  high in RUN or FLUSH.
- done  out  1  one-cycle pulse when the run completes.
- err  out  1  sticky; set on start with len==0 or nfrm==0; cleared by the next valid start.
- beat_cnt  out  LW  beats accepted in the current frame.
- frm_cnt  out  FW  frames fully accepted.
- S_AXIS_TVALID  in  1  from the accelerator.
- S_AXIS_TDATA  in  DW  from the accelerator.
- S_AXIS_TREADY  out  1  to the accelerator.
- M_AXIS_TVALID  out  1  to the DMA.
- M_AXIS_TDATA  out  DW  to the DMA.
- M_AXIS_TKEEP  out  DW/8  to the DMA; all ones whenever TVALID is high.
- M_AXIS_TLAST  out  1  to the DMA.
- M_AXIS_TREADY  in  1  from the DMA.

Behaviour:
- Reset (async, AXIS_ARESETN=0):
  - state=IDLE; buffer empty.
  - All outputs 0: busy, done, err, beat_cnt, frm_cnt, S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TKEEP.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: S_AXIS_TREADY=0.
    - start with len!=0 and nfrm!=0: latch len_r and nfrm_r; clear beat_cnt, frm_cnt and err; next state RUN.
    - start with len==0 or nfrm==0: set err, stay in IDLE.
    - start while not in IDLE: ignored.
  - RUN:
    - Input handshake: S_AXIS_TREADY = (buffer count < 2). Accept = S_AXIS_TVALID & S_AXIS_TREADY.
    - On accept: push {data, last}, where last = (beat_cnt == len_r-1).
    - If last: beat_cnt wraps to 0 and frm_cnt increments; otherwise beat_cnt increments.
    - When the accepted beat is last and frm_cnt == nfrm_r-1: next state FLUSH, and S_AXIS_TREADY drops the next cycle.
  - FLUSH: S_AXIS_TREADY=0. When the buffer is empty, assert done for one cycle and return to IDLE. frm_cnt holds its final value until the next start.
- Buffer: 2-entry FIFO of {TDATA, TLAST}.
  - M_AXIS_TVALID = not empty. Head entry drives M_AXIS_TDATA and M_AXIS_TLAST.
  - Pop on M_AXIS_TVALID & M_AXIS_TREADY.
  - Push and pop in the same cycle: count unchanged, order preserved.
- Latency: a beat accepted at edge k is visible on M_AXIS at cycle k+1 (registered, no combinational path S_AXIS->M_AXIS).
- Throughput: 1 beat/cycle sustained while M_AXIS_TREADY=1.
- Backpressure:
  - M_AXIS_TREADY low for 2+ cycles fills the buffer, and S_AXIS_TREADY goes low.
  - S_AXIS_TREADY depends only on registered state. No combinational path from M_AXIS_TREADY.
- AXIS rules:
  - M_AXIS_TVALID, once high, stays high with TDATA/TLAST stable until accepted.
  - TVALID never depends on TREADY.
- len==1: every beat carries TLAST.
- Counter wrap: beat_cnt never exceeds len_r-1; frm_cnt never exceeds nfrm_r.
- abort: highest priority in any state.
  - Buffer cleared; M_AXIS_TVALID=0 next cycle; S_AXIS_TREADY=0.
  - Counters cleared; state=IDLE; no done pulse.
  - abort and start in the same cycle: abort wins.
- Reset mid-operation: immediate return to the reset values above; any partial frame is discarded.

Decomposition:
- Shared package tiny_dnn_axis_pkg holds:
  - the state enum (IDLE/RUN/FLUSH);
  - default widths DW/LW/FW;
  - the beat-record typedef {data, last}.
- One sub-module: tiny_dnn_axis_skid. It is the 2-entry FIFO with push/pop/count, flush input and registered outputs; it is reused later for the input path.

Test Plan:
- len=4, nfrm=2, source always valid, sink always ready -> 8 beats out back-to-back; TLAST on beats 4 and 8; done pulses one cycle after the last M handshake; frm_cnt=2.
- len=1, nfrm=3 -> 3 beats, each with TLAST=1; busy is high for 3+ cycles then drops together with the done pulse.
- len=3, nfrm=1, M_AXIS_TREADY held low for 5 cycles -> exactly 2 beats buffered and S_AXIS_TREADY=0; data is stable; in-order delivery once ready returns.
- start with len=0 -> err=1, busy stays 0; then start with len=2, nfrm=1 -> err clears and a normal 2-beat frame is delivered.
- abort after 2 of 4 beats, with one beat pending in the buffer -> M_AXIS_TVALID=0 next cycle, no done pulse; beat_cnt and frm_cnt return to 0.
- AXIS_ARESETN asserted mid-frame with M_AXIS_TVALID high -> all outputs 0 immediately (asynchronously); a new start after deassertion produces a clean frame.
